exu_wb_port_arbiter: RTL and testbench
======================================

// Module: exu_wb_port_arbiter
// PURPOSE
// - Shares one integer register-file writeback port among a fixed-latency ALU pipe and NUM_VAR variable-latency units (div, etc.).
// - Sits at the execution-unit output, in front of the iresp/regfile write.
// - The fixed pipe always wins; variable units are served round-robin and drop killed responses.
// - A starvation counter asks the issue scheduler to hold ALU issue.
// PARAMETERS
// - NUM_VAR     2   variable-latency requesters (>=1)
// - DATA_W      64  result width; wb_data is DATA_W+1 with MSB=0
// - BR_W        20  branch-mask width
// - STARVE_MAX  4   consecutive denied cycles before fix_hold asserts (1..15)
// PORTS
// - clock           in   1              clock
// - reset           in   1              sync, active-low
// - fix_valid       in   1              fixed-pipe result valid (no ready; must be accepted)
// - fix_uop         in   wb_uop_t       rob_idx[6:0], pdst[6:0], dst_rtype[1:0]
// - fix_data        in   DATA_W         fixed-pipe result
// - var_valid       in   NUM_VAR        variable-unit result valid
// - var_ready       out  NUM_VAR        grant; transfer = valid&ready
// - var_uop         in   NUM_VAR*wb_uop_t  per-unit uop
// - var_br_mask     in   NUM_VAR*BR_W   per-unit branch mask
// - var_data        in   NUM_VAR*DATA_W per-unit result
// - brupdate_b1_mispredict_mask  in  BR_W  mispredicted branches this cycle
// - wb_valid        out  1              registered writeback valid
// - wb_uop          out  wb_uop_t       registered writeback uop
// - wb_data         out  DATA_W+1       {1'b0, result}
// - fix_hold        out  1              request scheduler to stop ALU issue
// BEHAVIOUR
// - Reset (reset==0 at posedge): wb_valid=0, wb_uop=0, wb_data=0, fix_hold=0, rr_ptr=0, starve_cnt=0.
//   Reset mid-operation discards any in-flight grant; var_ready is 0 while reset==0.
// - Grant (combinational, same cycle):
//   - fix_valid=1: no var_ready asserted; fixed result is registered.
//   - else: first i with var_valid[i], searching from rr_ptr upward with wrap; var_ready[i]=1, one-hot.
// - Latency: 1 cycle. Granted data appears on wb_* the next cycle; no bypass path.
// - Kill: if (var_br_mask[i] & mispredict_mask)!=0 for the granted i:
//   - var_ready[i]=1 (entry is consumed);
//   - next wb_valid=0.
//   - Killed valids still count as requests for arbitration.
// - rr_ptr: on any var transfer of unit i, rr_ptr <= (i+1) mod NUM_VAR. Otherwise unchanged.
// - starve_cnt:
//   - resets to 0 on a var transfer, or when no var_valid is pending;
//   - increments (saturating at STARVE_MAX) when any var_valid=1 and fix_valid=1.
// - fix_hold: registered; 1 while starve_cnt==STARVE_MAX, cleared the cycle after a var transfer.
//   Scheduler drains the ALU pipe; fix_valid then drops and a var unit wins.
// - No grant: wb_valid<=0; wb_uop and wb_data hold their last value.
// - Simultaneous fix_valid with all var_valid: fix wins, counter increments, rr_ptr holds.
// - wb_data[DATA_W] is always 0.
// CONFIGURATION
// - WB_ARB_PERF_EN defined: adds outputs perf_fix_cnt, perf_var_cnt, perf_hold_cnt, each 32-bit, wrapping at 2^32.
//   - perf_fix_cnt: fixed writebacks.
//   - perf_var_cnt: non-killed var writebacks.
//   - perf_hold_cnt: cycles with fix_hold=1.
//   - All reset to 0.
// - WB_ARB_PERF_EN undefined: these ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
// - Package exu_wb_pkg holds: wb_uop_t struct, WB_DATA_W, BR_W localparams, and the 2'h3-style dst_rtype constants.
// - Sub-module wb_rr_pick (NUM_VAR): rotating priority pick from a valid vector and ptr.
//   Outputs a one-hot grant and its index.
// - Top-level holds: fix-priority mux, kill check, starvation counter, output register, optional perf counters.
// TESTING
// - Reset low 3 cycles with all valids=1 -> var_ready=0, wb_valid=0, fix_hold=0.
//   Release reset -> first grant goes to var 0.
// - fix_valid=1, pdst=7'h12, data=64'h5 -> next cycle wb_valid=1, wb_uop.pdst=7'h12, wb_data=65'h5, var_ready=0.
// - NUM_VAR=2, both var_valid held 4 cycles, fix_valid=0 -> grants 0,1,0,1; rr_ptr wraps.
// - fix_valid=1 for 6 cycles with var_valid[1]=1, STARVE_MAX=4 -> fix_hold=1 from cycle 5.
//   Drop fix_valid -> var 1 granted, fix_hold=0 the following cycle.
// - var 0 granted, br_mask=20'h8, mispredict=20'h8 -> var_ready[0]=1, next wb_valid=0, rr_ptr=1.
// - WB_ARB_PERF_EN: 3 fix + 2 var writebacks + 1 killed -> perf_fix_cnt=3, perf_var_cnt=2.

Source files
------------

// File: rtl/exu_wb_pkg.sv
// Shared types and constants for the integer writeback port arbiter.
package exu_wb_pkg;

  localparam int WB_DATA_W = 64;
  localparam int BR_W      = 20;

  localparam logic [1:0] RT_FIX = 2'h0;
  localparam logic [1:0] RT_FLT = 2'h1;
  localparam logic [1:0] RT_X   = 2'h2;
  localparam logic [1:0] RT_PAS = 2'h3;

  typedef struct packed {
    logic [6:0] rob_idx;
    logic [6:0] pdst;
    logic [1:0] dst_rtype;
  } wb_uop_t;

endpackage

// File: rtl/wb_rr_pick.sv
// Rotating-priority pick: first set bit of valid_i at or above ptr_i, wrapping.
module wb_rr_pick #(
  parameter int NUM_VAR = 2,
  parameter int PTR_W   = (NUM_VAR > 1) ? $clog2(NUM_VAR) : 1
) (
  input  logic [NUM_VAR-1:0] valid_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_VAR-1:0] gnt_o,
  output logic [PTR_W-1:0]   idx_o,
  output logic               any_o
);

  int cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = 0;
    for (int off = 0; off < NUM_VAR; off++) begin
      cand = int'(ptr_i) + off;
      if (cand >= NUM_VAR) cand = cand - NUM_VAR;
      for (int i = 0; i < NUM_VAR; i++) begin
        if (!any_o && valid_i[i] && (i == cand)) begin
          any_o    = 1'b1;
          gnt_o[i] = 1'b1;
          idx_o    = PTR_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/exu_wb_port_arbiter.sv
// Shares one integer writeback port between the fixed ALU pipe and NUM_VAR variable-latency units.
// WB_ARB_PERF_EN adds 32-bit performance counter outputs.
module exu_wb_port_arbiter #(
  parameter int NUM_VAR    = 2,
  parameter int DATA_W     = exu_wb_pkg::WB_DATA_W,
  parameter int BR_W       = exu_wb_pkg::BR_W,
  parameter int STARVE_MAX = 4
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  fix_valid,
  input  exu_wb_pkg::wb_uop_t                   fix_uop,
  input  logic [DATA_W-1:0]                     fix_data,
  input  logic [NUM_VAR-1:0]                    var_valid,
  output logic [NUM_VAR-1:0]                    var_ready,
  input  exu_wb_pkg::wb_uop_t [NUM_VAR-1:0]     var_uop,
  input  logic [NUM_VAR-1:0][BR_W-1:0]          var_br_mask,
  input  logic [NUM_VAR-1:0][DATA_W-1:0]        var_data,
  input  logic [BR_W-1:0]                       brupdate_b1_mispredict_mask,
  output logic                                  wb_valid,
  output exu_wb_pkg::wb_uop_t                   wb_uop,
  output logic [DATA_W:0]                       wb_data,
`ifdef WB_ARB_PERF_EN
  output logic [31:0]                           perf_fix_cnt,
  output logic [31:0]                           perf_var_cnt,
  output logic [31:0]                           perf_hold_cnt,
`endif
  output logic                                  fix_hold
);

  import exu_wb_pkg::*;

  localparam int PTR_W = (NUM_VAR > 1) ? $clog2(NUM_VAR) : 1;

  // Handshake: a var unit transfers when var_valid[i] & var_ready[i]; the fixed pipe has no ready.
  logic [NUM_VAR-1:0] pick_gnt;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_any;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [3:0]         starve_q, starve_d;
  logic               fix_hold_q, fix_hold_d;
  logic               wb_valid_q, wb_valid_d;
  wb_uop_t            wb_uop_q, wb_uop_d;
  logic [DATA_W-1:0]  wb_data_q, wb_data_d;
  logic               var_xfer, var_kill;

  wb_rr_pick #(.NUM_VAR(NUM_VAR), .PTR_W(PTR_W)) u_pick (
    .valid_i (var_valid),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  assign var_ready = (reset && !fix_valid) ? pick_gnt : '0;
  assign var_xfer  = |var_ready;

  always_comb begin
    var_kill   = 1'b0;
    rr_ptr_d   = rr_ptr_q;
    wb_uop_d   = wb_uop_q;
    wb_data_d  = wb_data_q;
    wb_valid_d = 1'b0;
    for (int i = 0; i < NUM_VAR; i++) begin
      if (var_ready[i]) begin
        var_kill = |(var_br_mask[i] & brupdate_b1_mispredict_mask);
        rr_ptr_d = (i == NUM_VAR - 1) ? '0 : PTR_W'(i + 1);
        if (!var_kill) begin
          wb_valid_d = 1'b1;
          wb_uop_d   = var_uop[i];
          wb_data_d  = var_data[i];
        end
      end
    end
    if (fix_valid) begin
      wb_valid_d = 1'b1;
      wb_uop_d   = fix_uop;
      wb_data_d  = fix_data;
    end
  end

  // Killed requests still block the fixed-pipe starvation path like live ones.
  always_comb begin
    starve_d = starve_q;
    if (var_xfer || !(|var_valid)) starve_d = '0;
    else if (fix_valid && starve_q != 4'(STARVE_MAX)) starve_d = starve_q + 4'd1;
    fix_hold_d = (starve_d == 4'(STARVE_MAX));
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rr_ptr_q   <= '0;
      starve_q   <= '0;
      fix_hold_q <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_uop_q   <= '0;
      wb_data_q  <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      starve_q   <= starve_d;
      fix_hold_q <= fix_hold_d;
      wb_valid_q <= wb_valid_d;
      wb_uop_q   <= wb_uop_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_uop   = wb_uop_q;
  assign wb_data  = {1'b0, wb_data_q};
  assign fix_hold = fix_hold_q;

`ifdef WB_ARB_PERF_EN
  logic [31:0] perf_fix_q, perf_var_q, perf_hold_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      perf_fix_q  <= '0;
      perf_var_q  <= '0;
      perf_hold_q <= '0;
    end else begin
      if (fix_valid)             perf_fix_q  <= perf_fix_q + 32'd1;
      if (var_xfer && !var_kill) perf_var_q  <= perf_var_q + 32'd1;
      if (fix_hold_q)            perf_hold_q <= perf_hold_q + 32'd1;
    end
  end

  assign perf_fix_cnt  = perf_fix_q;
  assign perf_var_cnt  = perf_var_q;
  assign perf_hold_cnt = perf_hold_q;
`endif

  logic unused_ok;
  assign unused_ok = pick_any ^ (|pick_idx);

endmodule

// File: tb/tb_exu_wb_port_arbiter.sv
// Directed-vector bench for exu_wb_port_arbiter (NUM_VAR=2, STARVE_MAX=4).
module tb_exu_wb_port_arbiter;

  logic                             clock;
  logic                             reset;
  logic                             fix_valid;
  exu_wb_pkg::wb_uop_t              fix_uop;
  logic [63:0]                      fix_data;
  logic [1:0]                       var_valid;
  logic [1:0]                       var_ready;
  exu_wb_pkg::wb_uop_t [1:0]        var_uop;
  logic [1:0][19:0]                 var_br_mask;
  logic [1:0][63:0]                 var_data;
  logic [19:0]                      mispred;
  logic                             wb_valid;
  exu_wb_pkg::wb_uop_t              wb_uop;
  logic [64:0]                      wb_data;
  logic                             fix_hold;
`ifdef WB_ARB_PERF_EN
  logic [31:0] perf_fix_cnt, perf_var_cnt, perf_hold_cnt;
`endif

  int total = 0;
  int bad   = 0;

  exu_wb_port_arbiter #(.NUM_VAR(2), .DATA_W(64), .BR_W(20), .STARVE_MAX(4)) dut (
    .clock                       (clock),
    .reset                       (reset),
    .fix_valid                   (fix_valid),
    .fix_uop                     (fix_uop),
    .fix_data                    (fix_data),
    .var_valid                   (var_valid),
    .var_ready                   (var_ready),
    .var_uop                     (var_uop),
    .var_br_mask                 (var_br_mask),
    .var_data                    (var_data),
    .brupdate_b1_mispredict_mask (mispred),
    .wb_valid                    (wb_valid),
    .wb_uop                      (wb_uop),
    .wb_data                     (wb_data),
`ifdef WB_ARB_PERF_EN
    .perf_fix_cnt                (perf_fix_cnt),
    .perf_var_cnt                (perf_var_cnt),
    .perf_hold_cnt               (perf_hold_cnt),
`endif
    .fix_hold                    (fix_hold)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; return 2 time units later so registered outputs are settled.
  task automatic step();
    @(posedge clock);
    #2;
  endtask

  // Apply new inputs and let combinational outputs settle.
  task automatic drive(input logic fv, input logic [1:0] vv, input logic [19:0] mp);
    fix_valid = fv;
    var_valid = vv;
    mispred   = mp;
    #1;
  endtask

  localparam logic [63:0] D0 = 64'h0000_00A0_0000_00A0;
  localparam logic [63:0] D1 = 64'h0000_00B1_0000_00B1;

  initial begin
    reset       = 1'b0;
    fix_uop     = '{rob_idx: 7'h21, pdst: 7'h12, dst_rtype: exu_wb_pkg::RT_FIX};
    fix_data    = 64'h5;
    var_uop[0]  = '{rob_idx: 7'h30, pdst: 7'h40, dst_rtype: exu_wb_pkg::RT_FIX};
    var_uop[1]  = '{rob_idx: 7'h31, pdst: 7'h41, dst_rtype: exu_wb_pkg::RT_FIX};
    var_br_mask = '0;
    var_data[0] = D0;
    var_data[1] = D1;
    drive(1'b0, 2'b11, 20'h0);

    // reset held with requests pending
    for (int c = 0; c < 3; c++) begin
      step();
      check("rst_ready", 128'(var_ready), 128'(2'b00));
    end
    check("rst_wb_valid", 128'(wb_valid), 128'(1'b0));
    check("rst_fix_hold", 128'(fix_hold), 128'(1'b0));
    check("rst_wb_data", 128'(wb_data), 128'(65'h0));
    check("rst_wb_uop", 128'(wb_uop), 128'(16'h0));

    // round robin 0,1,0,1
    reset = 1'b1;
    #1;
    check("rr_ready0", 128'(var_ready), 128'(2'b01));
    step();
    check("rr_data0", 128'(wb_data), 128'({1'b0, D0}));
    check("rr_uop0", 128'(wb_uop), 128'({7'h30, 7'h40, 2'h0}));
    check("rr_ready1", 128'(var_ready), 128'(2'b10));
    step();
    check("rr_data1", 128'(wb_data), 128'({1'b0, D1}));
    check("rr_ready2", 128'(var_ready), 128'(2'b01));
    step();
    check("rr_data2", 128'(wb_data), 128'({1'b0, D0}));
    check("rr_ready3", 128'(var_ready), 128'(2'b10));
    step();
    check("rr_data3", 128'(wb_data), 128'({1'b0, D1}));
    check("rr_valid3", 128'(wb_valid), 128'(1'b1));

    // fixed pipe wins over a pending var request
    drive(1'b1, 2'b01, 20'h0);
    check("fix_ready", 128'(var_ready), 128'(2'b00));
    step();
    check("fix_valid", 128'(wb_valid), 128'(1'b1));
    check("fix_pdst", 128'(wb_uop.pdst), 128'(7'h12));
    check("fix_rob", 128'(wb_uop.rob_idx), 128'(7'h21));
    check("fix_data", 128'(wb_data), 128'(65'h5));
    drive(1'b0, 2'b00, 20'h0);
    step();
    check("idle_valid", 128'(wb_valid), 128'(1'b0));
    check("idle_hold_data", 128'(wb_data), 128'(65'h5));

    // starvation: var 1 denied while fix_valid stays high
    drive(1'b1, 2'b10, 20'h0);
    for (int c = 1; c <= 6; c++) begin
      step();
      check("starve_ready", 128'(var_ready), 128'(2'b00));
      check("starve_hold", 128'(fix_hold), 128'(c >= 4));
    end
    drive(1'b0, 2'b10, 20'h0);
    check("starve_grant1", 128'(var_ready), 128'(2'b10));
    step();
    check("starve_hold_clr", 128'(fix_hold), 128'(1'b0));
    check("starve_wb_data", 128'(wb_data), 128'({1'b0, D1}));
    check("starve_wb_valid", 128'(wb_valid), 128'(1'b1));

    // killed response is consumed but not written back
    var_br_mask[0] = 20'h8;
    drive(1'b0, 2'b01, 20'h8);
    check("kill_ready", 128'(var_ready), 128'(2'b01));
    step();
    check("kill_wb_valid", 128'(wb_valid), 128'(1'b0));
    check("kill_hold_data", 128'(wb_data), 128'({1'b0, D1}));
    drive(1'b0, 2'b11, 20'h0);
    check("kill_rr_ptr1", 128'(var_ready), 128'(2'b10));
    var_br_mask[0] = 20'h0;

    // reset mid-operation drops the pending grant
    reset = 1'b0;
    #1;
    check("midrst_ready", 128'(var_ready), 128'(2'b00));
    step();
    check("midrst_valid", 128'(wb_valid), 128'(1'b0));
    check("midrst_data", 128'(wb_data), 128'(65'h0));
    drive(1'b0, 2'b00, 20'h0);
    reset = 1'b1;

`ifdef WB_ARB_PERF_EN
    drive(1'b1, 2'b00, 20'h0);
    step(); step(); step();
    drive(1'b0, 2'b01, 20'h0);
    step(); step();
    var_br_mask[0] = 20'h4;
    drive(1'b0, 2'b01, 20'h4);
    step();
    drive(1'b0, 2'b00, 20'h0);
    step();
    check("perf_fix", 128'(perf_fix_cnt), 128'(32'd3));
    check("perf_var", 128'(perf_var_cnt), 128'(32'd2));
    check("perf_hold", 128'(perf_hold_cnt), 128'(32'd0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
